fifo_wr_ptr_full: RTL and testbench

Write-side control for the asynchronous FIFO, running in the wr_clk domain directly upstream of the dual-port RAM. It owns the binary/Gray write pointer and drives the RAM write address. It brings the read-domain Gray pointer across with a 2-flop synchronizer and generates wr_full, wr_almost_full and a fill level. Its Gray pointer output goes to the read-domain synchronizer.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_sync_2ff.sv | 25 ++
 rtl/fifo_wr_ptr_full.sv | 72 +++++++
 tb/tb_fifo_wr_ptr_full.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks (write and read side).
// Gray/binary conversions work on zero-extended values up to CODE_MAX_W bits wide.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 5;
    localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;
    localparam int CODE_MAX_W      = 32;

    function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero upper bits leave the prefix-XOR unchanged, so callers may pass any narrower code.
    function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] gray);
        logic [CODE_MAX_W-1:0] bin;
        bin[CODE_MAX_W-1] = gray[CODE_MAX_W-1];
        for (int i = CODE_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module fifo_sync_2ff
    import fifo_pkg::*;
#(
    parameter int WIDTH = PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer and full/level generation for the asynchronous FIFO (wr_clk domain).
module fifo_wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray
);

    localparam int PW        = ADDR_WIDTH + 1;
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THRESH = PW'(RAM_DEPTH - ALMOST_FULL_MARGIN);

    logic [PW-1:0] wr_ptr_bin;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rd_ptr_bin;
    logic          accept;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          almost_full_next;

    fifo_sync_2ff #(
        .WIDTH(PW)
    ) u_rd_sync (
        .clk  (wr_clk),
        .rst_n(wr_rst_n),
        .d    (rd_ptr_gray),
        .q    (rq2)
    );

    assign rd_ptr_bin = PW'(gray2bin(CODE_MAX_W'(rq2)));

    // The RAM qualifies its write strobe with the same !wr_full term.
    assign accept     = write_enable && !wr_full;
    assign bin_next   = wr_ptr_bin + {{ADDR_WIDTH{1'b0}}, accept};
    assign gray_next  = PW'(bin2gray(CODE_MAX_W'(bin_next)));
    assign level_next = bin_next - rd_ptr_bin;

    // Full when the pointers differ only in the two MSBs of their Gray codes (one lap ahead).
    assign full_next = (gray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]});
    assign almost_full_next = (level_next >= AF_THRESH);

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            wr_ptr_bin     <= '0;
            wr_ptr_gray    <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
        end else begin
            wr_ptr_bin     <= bin_next;
            wr_ptr_gray    <= gray_next;
            wr_full        <= full_next;
            wr_almost_full <= almost_full_next;
            wr_level       <= level_next;
        end
    end

    assign write_addr = wr_ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Scoreboard bench for fifo_wr_ptr_full: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_fifo_wr_ptr_full;

    typedef struct packed {
        logic [4:0] addr;
        logic [5:0] gray;
        logic       full;
        logic       af;
        logic [5:0] level;
    } exp_t;

    logic       wr_clk = 1'b0;
    logic       wr_rst_n = 1'b0;
    logic       write_enable = 1'b0;
    logic [5:0] rd_ptr_gray = '0;
    logic [4:0] write_addr;
    logic       wr_full;
    logic       wr_almost_full;
    logic [5:0] wr_level;
    logic [5:0] wr_ptr_gray;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic wrap_phase = 1'b0;
    logic [5:0] prev_gray = '0;

    logic [5:0] m_bin = '0;
    logic [5:0] m_r1 = '0;
    logic [5:0] m_r2 = '0;
    logic       m_full = 1'b0;

    fifo_wr_ptr_full #(
        .ADDR_WIDTH(5),
        .ALMOST_FULL_MARGIN(4)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_rst_n      (wr_rst_n),
        .write_enable  (write_enable),
        .rd_ptr_gray   (rd_ptr_gray),
        .write_addr    (write_addr),
        .wr_full       (wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_level      (wr_level),
        .wr_ptr_gray   (wr_ptr_gray)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [5:0] to_gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] to_bin(input logic [5:0] g);
        logic [5:0] b;
        for (int i = 0; i < 6; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, then advance the reference model at the same edge.
    task automatic tick(input logic we, input logic [5:0] rdg, input logic rstn);
        exp_t       e;
        logic [5:0] binn;
        logic [5:0] lvl;
        write_enable = we;
        rd_ptr_gray  = rdg;
        wr_rst_n     = rstn;
        @(posedge wr_clk);
        if (!rstn) begin
            m_bin = '0; m_r1 = '0; m_r2 = '0; m_full = 1'b0;
            e = '0;
        end else begin
            binn    = m_bin + ((we && !m_full) ? 6'd1 : 6'd0);
            lvl     = binn - to_bin(m_r2);
            m_full  = (lvl == 6'd32);
            e.addr  = binn[4:0];
            e.gray  = to_gray(binn);
            e.full  = m_full;
            e.af    = (lvl >= 6'd28);
            e.level = lvl;
            m_r2    = m_r1;
            m_r1    = rdg;
            m_bin   = binn;
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic settle();
        @(negedge wr_clk);
        #1;
    endtask

    always @(negedge wr_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("write_addr", write_addr, mon_e.addr);
            chk("wr_ptr_gray", wr_ptr_gray, mon_e.gray);
            chk("wr_full", wr_full, mon_e.full);
            chk("wr_almost_full", wr_almost_full, mon_e.af);
            chk("wr_level", wr_level, mon_e.level);
        end
        if (wrap_phase) chk("gray_one_bit_step", $countones(wr_ptr_gray ^ prev_gray), 1);
        prev_gray <= wr_ptr_gray;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with write_enable asserted
        repeat (3) tick(1'b1, 6'd0, 1'b0);
        settle();
        chk("reset_addr", write_addr, 0);
        chk("reset_gray", wr_ptr_gray, 0);
        chk("reset_full", wr_full, 0);
        chk("reset_level", wr_level, 0);

        // Fill to full, then one dropped write
        for (int i = 1; i <= 33; i++) begin
            tick(1'b1, 6'd0, 1'b1);
            if (i == 27) begin settle(); chk("af_before_28", wr_almost_full, 0); end
            if (i == 28) begin settle(); chk("af_at_28", wr_almost_full, 1); end
            if (i == 32) begin
                settle();
                chk("full_at_32", wr_full, 1);
                chk("level_at_32", wr_level, 32);
                chk("addr_at_32", write_addr, 0);
            end
            if (i == 33) begin
                settle();
                chk("drop_addr", write_addr, 0);
                chk("drop_gray", wr_ptr_gray, 6'b110000);
                chk("drop_full", wr_full, 1);
            end
        end

        // Release from full: one entry read
        tick(1'b0, 6'b000001, 1'b1);
        tick(1'b0, 6'b000001, 1'b1);
        settle();
        chk("release_full_edge2", wr_full, 1);
        tick(1'b0, 6'b000001, 1'b1);
        settle();
        chk("release_full_edge3", wr_full, 0);
        chk("release_level", wr_level, 31);
        chk("release_af", wr_almost_full, 1);

        // Wrap: 64 writes with the reader following
        repeat (2) tick(1'b0, 6'd0, 1'b0);
        settle();
        wrap_phase = 1'b1;
        for (int k = 1; k <= 64; k++) tick(1'b1, to_gray(6'(k)), 1'b1);
        settle();
        wrap_phase = 1'b0;
        chk("wrap_gray", wr_ptr_gray, 0);
        chk("wrap_addr", write_addr, 0);

        // Reset in the middle of writing
        repeat (10) tick(1'b1, 6'd0, 1'b1);
        settle();
        chk("pre_reset_addr", write_addr, 10);
        tick(1'b1, 6'd0, 1'b0);
        settle();
        chk("midreset_addr", write_addr, 0);
        chk("midreset_level", wr_level, 0);
        tick(1'b0, 6'd0, 1'b1);
        settle();
        chk("post_reset_addr", write_addr, 0);

        // One-cycle glitch on the read pointer
        repeat (4) tick(1'b1, 6'd0, 1'b1);
        tick(1'b0, 6'b000011, 1'b1);
        tick(1'b0, 6'd0, 1'b1);
        tick(1'b0, 6'd0, 1'b1);
        settle();
        chk("glitch_level", wr_level, 2);
        chk("glitch_addr", write_addr, 4);
        tick(1'b0, 6'd0, 1'b1);
        settle();
        chk("glitch_recover", wr_level, 4);
        chk("glitch_gray", wr_ptr_gray, 6'b000110);

        for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(negedge wr_clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
